alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
- Registered, sequenced successor to the single-cycle ALU control decoder.
- Decodes aluop/funct into ALU control (gout), branch-type select (rtypeout), branch-source select (rsordatamem) and jump-address control (jmaddcont).
- Adds a valid/ready handshake and an FSM for the multi-cycle custom ops: iterative sllv and two-phase jmadd.
- Sits between the main control unit and the ALU/PC-select datapath of the multicycle core.

Parameters:
- FUNCT_W, 6: funct field width. Decoded codes occupy the low 6 bits; any nonzero bit above bit 5 makes the funct illegal.
- SHAMT_W, 5: shift-amount width; sizes the iteration counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  aluop/funct/shamt valid this cycle
- in_ready  out  1  block can accept; combinational, high only in IDLE
- aluop  in  2  {aluop1, aluop0} from main control
- funct  in  FUNCT_W  instruction funct field
- shamt  in  SHAMT_W  shift amount for sllv (rs[SHAMT_W-1:0])
- gout  out  3  ALU control code
- rtypeout  out  3  100 normal, 001 brz, 010 jmadd
- rsordatamem  out  1  branch target from register (1) / other (0)
- jmaddcont  out  1  select memory data as next PC
- shift_en  out  1  ALU performs a 1-bit shift of its accumulator this cycle
- out_valid  out  1  one-cycle pulse: operation's final control word is on the outputs
- illegal  out  1  last accepted R-type funct was undecoded

Behaviour:
- Accept: in_valid & in_ready at a rising edge. All outputs except in_ready are registered. Outputs hold their last value when out_valid=0.
- Reset (synchronous, overrides everything, including mid-operation):
  - state goes to IDLE, counter to 0
  - gout=010, rtypeout=100, rsordatamem=0, jmaddcont=0, shift_en=0, out_valid=0, illegal=0
  - in_ready=1 in the cycle after reset
- States: IDLE, SHIFT, JM_ADDR, JM_JUMP.
- Decode rules. Every path assigns all four control outputs; there are no latched leftovers. Defaults are rtypeout=100, rsordatamem=0, jmaddcont=0, illegal=0.
  - aluop=00: gout=010.
  - aluop=10: gout=110.
  - aluop=01 or 11: R-type; aluop0 has priority. Funct decode:
    - 000000: gout=010, rsordatamem=1
    - 001010: gout=111
    - 100010: gout=110
    - 011001: gout=001
    - 101000: gout=000
    - 010100 (brz): gout=000, rtypeout=001, rsordatamem=1
    - 000100 (sllv): gout=011, multi-cycle (see SHIFT)
    - 100000 (jmadd): multi-cycle (see JM_ADDR/JM_JUMP)
    - any other funct: gout=010, illegal=1
- Single-cycle ops: decoded word and out_valid=1 appear the cycle after accept. State stays IDLE, so back-to-back accepts give 1 op/cycle.
- SHIFT (sllv, iterative mode):
  - On accept with shamt=0: single-cycle op, shift_en=0, out_valid next cycle.
  - Otherwise: cnt<=shamt and go to SHIFT. Each SHIFT cycle: gout=011, shift_en=1, cnt decrements.
  - On the cycle cnt==1: out_valid=1 and return to IDLE.
  - Exactly shamt shift_en cycles; shamt=2^SHAMT_W-1 gives 31 cycles with no wrap.
- JM_ADDR: gout=010, rtypeout=010, jmaddcont=0, out_valid=0. The ALU forms rs+rt as the memory address.
- JM_JUMP: jmaddcont=1, remaining outputs held, out_valid=1. Then return to IDLE. Total latency is 2 cycles from accept.
- in_valid while not in IDLE: ignored (in_ready=0). The source holds its inputs.

Optional Feature:
- Macro ALU_CTRL_SEQ_ITER_SHIFT_EN.
  - Defined: sllv uses the iterative SHIFT state as above.
  - Undefined: sllv is a single-cycle op (gout=011, shift_en tied 0, shamt ignored, SHIFT state not compiled).

Test Plan:
- Reset, then aluop=00 accept: next cycle gout=010, rtypeout=100, out_valid=1. Then aluop=10 back-to-back: gout=110 the following cycle with no bubble.
- aluop=01, funct=010100 (brz): gout=000, rtypeout=001, rsordatamem=1, jmaddcont=0, out_valid=1 one cycle after accept.
- aluop=01, funct=000100, shamt=3 (macro defined): shift_en=1 for exactly 3 cycles, gout=011, in_ready=0 for those 3 cycles, out_valid=1 on the 3rd. shamt=0: out_valid after 1 cycle with shift_en=0.
- aluop=01, funct=100000 (jmadd): cycle 1 gout=010, rtypeout=010, jmaddcont=0; cycle 2 jmaddcont=1, out_valid=1. A new in_valid during cycle 1 is not accepted.
- aluop=11, funct=111111: R-type priority, gout=010, illegal=1. A following legal op clears illegal.
- Assert reset during the 2nd SHIFT cycle (shamt=5): next cycle state IDLE, shift_en=0, out_valid=0, gout=010, in_ready=1. No stray out_valid afterwards.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with a valid/ready handshake and an FSM for the multi-cycle sllv and jmadd ops.
// Optional: define ALU_CTRL_SEQ_ITER_SHIFT_EN to run sllv as an iterative one-bit-per-cycle shift.
module alu_ctrl_seq #(
   parameter int FUNCT_W = 6,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         aluop,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [2:0]         gout,
   output logic [2:0]         rtypeout,
   output logic               rsordatamem,
   output logic               jmaddcont,
   output logic               shift_en,
   output logic               out_valid,
   output logic               illegal
);

   typedef enum logic [1:0] {
      ST_IDLE,
`ifdef ALU_CTRL_SEQ_ITER_SHIFT_EN
      ST_SHIFT,
`endif
      ST_JM_ADDR,
      ST_JM_JUMP
   } state_t;

   typedef enum logic [1:0] {
      OP_SINGLE,
      OP_SHIFT,
      OP_JMADD
   } op_kind_t;

   state_t     r_state;
   logic [2:0] r_gout;
   logic [2:0] r_rtypeout;
   logic       r_rsordatamem;
   logic       r_jmaddcont;
   logic       r_out_valid;
   logic       r_illegal;

   logic [2:0] w_gout;
   logic [2:0] w_rtypeout;
   logic       w_rsordatamem;
   logic       w_illegal;
   op_kind_t   w_kind;
   logic       w_funct_legal;

   // Only the low 6 funct bits carry a code; anything set above them is undecodable.
   assign w_funct_legal = ((funct >> 6) == '0);

   // NOTE: every decode output gets a default before the branches, so no path can infer a latch.
   always_comb begin
      w_gout        = 3'b010;
      w_rtypeout    = 3'b100;
      w_rsordatamem = 1'b0;
      w_illegal     = 1'b0;
      w_kind        = OP_SINGLE;
      if (aluop[0]) begin
         if (!w_funct_legal) begin
            w_illegal = 1'b1;
         end else begin
            case (funct[5:0])
               6'b000000: w_rsordatamem = 1'b1;
               6'b001010: w_gout = 3'b111;
               6'b100010: w_gout = 3'b110;
               6'b011001: w_gout = 3'b001;
               6'b101000: w_gout = 3'b000;
               6'b010100: begin
                  w_gout        = 3'b000;
                  w_rtypeout    = 3'b001;
                  w_rsordatamem = 1'b1;
               end
               6'b000100: begin
                  w_gout = 3'b011;
`ifdef ALU_CTRL_SEQ_ITER_SHIFT_EN
                  if (shamt != '0) w_kind = OP_SHIFT;
`endif
               end
               6'b100000: begin
                  w_rtypeout = 3'b010;
                  w_kind     = OP_JMADD;
               end
               default: w_illegal = 1'b1;
            endcase
         end
      end else if (aluop[1]) begin
         w_gout = 3'b110;
      end
   end

`ifdef ALU_CTRL_SEQ_ITER_SHIFT_EN
   logic [SHAMT_W-1:0] r_cnt;
   logic               r_shift_en;
`else
   logic w_unused;
   assign w_unused = ^shamt;
`endif

   // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_gout        <= 3'b010;
         r_rtypeout    <= 3'b100;
         r_rsordatamem <= 1'b0;
         r_jmaddcont   <= 1'b0;
         r_out_valid   <= 1'b0;
         r_illegal     <= 1'b0;
`ifdef ALU_CTRL_SEQ_ITER_SHIFT_EN
         r_cnt         <= '0;
         r_shift_en    <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_out_valid <= 1'b0;
`ifdef ALU_CTRL_SEQ_ITER_SHIFT_EN
               r_shift_en  <= 1'b0;
`endif
               if (in_valid) begin
                  r_gout        <= w_gout;
                  r_rtypeout    <= w_rtypeout;
                  r_rsordatamem <= w_rsordatamem;
                  r_jmaddcont   <= 1'b0;
                  r_illegal     <= w_illegal;
                  case (w_kind)
                     OP_JMADD: r_state <= ST_JM_ADDR;
`ifdef ALU_CTRL_SEQ_ITER_SHIFT_EN
                     OP_SHIFT: begin
                        r_state     <= ST_SHIFT;
                        r_cnt       <= shamt;
                        r_shift_en  <= 1'b1;
                        r_out_valid <= (shamt == SHAMT_W'(1));
                     end
`endif
                     default: r_out_valid <= 1'b1;
                  endcase
               end
            end
`ifdef ALU_CTRL_SEQ_ITER_SHIFT_EN
            // The cycle holding cnt==1 is the last shift and carries out_valid.
            ST_SHIFT: begin
               r_cnt <= r_cnt - SHAMT_W'(1);
               if (r_cnt == SHAMT_W'(1)) begin
                  r_state     <= ST_IDLE;
                  r_shift_en  <= 1'b0;
                  r_out_valid <= 1'b0;
               end else begin
                  r_out_valid <= (r_cnt == SHAMT_W'(2));
               end
            end
`endif
            ST_JM_ADDR: begin
               r_state     <= ST_JM_JUMP;
               r_jmaddcont <= 1'b1;
               r_out_valid <= 1'b1;
            end
            ST_JM_JUMP: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready    = (r_state == ST_IDLE);
   assign gout        = r_gout;
   assign rtypeout    = r_rtypeout;
   assign rsordatamem = r_rsordatamem;
   assign jmaddcont   = r_jmaddcont;
   assign out_valid   = r_out_valid;
   assign illegal     = r_illegal;
`ifdef ALU_CTRL_SEQ_ITER_SHIFT_EN
   assign shift_en    = r_shift_en;
`else
   assign shift_en    = 1'b0;
`endif

endmodule
